// File: rtl/alu_pipe_pkg.sv
// Shared types and helpers for the alu_pipe two-stage signed ALU.
// The saturating adder works at a fixed wide width so it can serve any OUT_W below MaxW.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_MUL     = 3'b010,
        OP_MAC     = 3'b011,
        OP_MAX     = 3'b100,
        OP_MIN     = 3'b101,
        OP_ABSDIFF = 3'b110,
        OP_CLR     = 3'b111
    } op_e;

    localparam int unsigned MaxW = 128;

    typedef struct packed {
        logic                   sat;
        logic signed [MaxW-1:0] value;
    } sat_res_t;

    // acc and prod arrive sign-extended from out_w bits; the wide sum cannot wrap.
    function automatic sat_res_t sat_add(input logic signed [MaxW-1:0] acc,
                                         input logic signed [MaxW-1:0] prod,
                                         input int unsigned            out_w);
        logic signed [MaxW-1:0] sum;
        logic signed [MaxW-1:0] hi;
        logic signed [MaxW-1:0] lim;
        sat_res_t               res;
        sum = acc + prod;
        hi  = sum >>> (out_w - 1);
        lim = {MaxW{1'b1}} << (out_w - 1);
        res.sat = (hi != '0) && (hi != '1);
        if (!res.sat) begin
            res.value = sum;
        end else if (sum[MaxW-1]) begin
            res.value = lim;
        end else begin
            res.value = ~lim;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand-side and result-side valid/ready handshake of alu_pipe.
// slave is the ALU's view; master is the driver/consumer view.
interface alu_pipe_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 2 * DATA_W
);
    logic                     valid_i;
    logic                     ready_o;
    logic signed [DATA_W-1:0] data_a_i;
    logic signed [DATA_W-1:0] data_b_i;
    logic [2:0]               inst_i;
    logic                     valid_o;
    logic                     ready_i;
    logic signed [OUT_W-1:0]  data_o;
    logic                     sat_o;

    modport slave (
        input  valid_i, data_a_i, data_b_i, inst_i, ready_i,
        output ready_o, valid_o, data_o, sat_o
    );

    modport master (
        output valid_i, data_a_i, data_b_i, inst_i, ready_i,
        input  ready_o, valid_o, data_o, sat_o
    );
endinterface

// File: rtl/alu_pipe_mac.sv
// Saturating multiply-accumulate register for alu_pipe.
// acc_o is the current value; mac_o/sat_o give the would-be MAC result this cycle.
module alu_pipe_mac
    import alu_pipe_pkg::*;
#(
    parameter int unsigned OUT_W = 16
) (
    input  logic                    clk_p_i,
    input  logic                    reset_p_i,
    input  logic                    mac_en_i,
    input  logic                    clr_en_i,
    input  logic signed [OUT_W-1:0] prod_i,
    output logic signed [OUT_W-1:0] acc_o,
    output logic signed [OUT_W-1:0] mac_o,
    output logic                    sat_o
);
    logic signed [OUT_W-1:0] acc_q, acc_d;
    sat_res_t                res;
    logic                    unused_hi;

    always_comb begin
        res = sat_add({{(MaxW - OUT_W){acc_q[OUT_W-1]}}, acc_q},
                      {{(MaxW - OUT_W){prod_i[OUT_W-1]}}, prod_i}, OUT_W);
        acc_d = acc_q;
        if (mac_en_i) begin
            acc_d = res.value[OUT_W-1:0];
        end else if (clr_en_i) begin
            acc_d = '0;
        end
    end

    assign unused_hi = ^res.value[MaxW-1:OUT_W];
    assign acc_o     = acc_q;
    assign mac_o     = res.value[OUT_W-1:0];
    assign sat_o     = res.sat;

    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined signed ALU: S1 registers the operation, S2 computes and
// registers the result. Stalls propagate backwards from the result handshake.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 2 * DATA_W
) (
    input logic       clk_p_i,
    input logic       reset_p_i,
    alu_pipe_if.slave bus
);
    logic                     adv1, adv2, commit;
    logic                     s1_valid_q, s1_valid_d;
    op_e                      s1_inst_q, s1_inst_d;
    logic signed [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic                     s2_valid_q, s2_valid_d, s2_sat_q, s2_sat_d;
    logic signed [OUT_W-1:0]  s2_data_q, s2_data_d;
    logic signed [OUT_W-1:0]  a_ext, b_ext, prod, diff, acc_old, acc_mac, result;
    logic                     mac_sat, result_sat;

    assign adv2   = !s2_valid_q || bus.ready_i;
    assign adv1   = !s1_valid_q || adv2;
    assign commit = s1_valid_q && adv2;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_inst_d  = s1_inst_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (adv1) begin
            s1_valid_d = bus.valid_i;
            if (bus.valid_i) begin
                s1_inst_d = op_e'(bus.inst_i);
                s1_a_d    = bus.data_a_i;
                s1_b_d    = bus.data_b_i;
            end
        end
    end

    assign a_ext = {{(OUT_W - DATA_W){s1_a_q[DATA_W-1]}}, s1_a_q};
    assign b_ext = {{(OUT_W - DATA_W){s1_b_q[DATA_W-1]}}, s1_b_q};
    assign prod  = a_ext * b_ext;
    assign diff  = a_ext - b_ext;

    // Accumulator only moves when its MAC/CLR leaves S1, so a stall never double-commits.
    alu_pipe_mac #(
        .OUT_W(OUT_W)
    ) u_mac (
        .clk_p_i  (clk_p_i),
        .reset_p_i(reset_p_i),
        .mac_en_i (commit && (s1_inst_q == OP_MAC)),
        .clr_en_i (commit && (s1_inst_q == OP_CLR)),
        .prod_i   (prod),
        .acc_o    (acc_old),
        .mac_o    (acc_mac),
        .sat_o    (mac_sat)
    );

    always_comb begin
        result     = '0;
        result_sat = 1'b0;
        case (s1_inst_q)
            OP_ADD:     result = a_ext + b_ext;
            OP_SUB:     result = diff;
            OP_MUL:     result = prod;
            OP_MAC: begin
                result     = acc_mac;
                result_sat = mac_sat;
            end
            OP_MAX:     result = (a_ext > b_ext) ? a_ext : b_ext;
            OP_MIN:     result = (a_ext < b_ext) ? a_ext : b_ext;
            OP_ABSDIFF: result = diff[OUT_W-1] ? -diff : diff;
            OP_CLR:     result = acc_old;
            default:    result = '0;
        endcase
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = result;
                s2_sat_d  = result_sat;
            end
        end
    end

    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            s1_valid_q <= 1'b0;
            s1_inst_q  <= OP_ADD;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_inst_q  <= s1_inst_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

    assign bus.ready_o = adv1;
    assign bus.valid_o = s2_valid_q;
    assign bus.data_o  = s2_data_q;
    assign bus.sat_o   = s2_sat_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: default (8/16) and narrow (4/8) instances,
// directed cases plus randomized streams against an arithmetic reference model.
module tb_alu_pipe;
    typedef struct packed {logic [15:0] d; logic s;} res8_t;
    typedef struct packed {logic [7:0] d; logic s;} res4_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.DATA_W(8), .OUT_W(16)) bus8 ();
    alu_pipe_if #(.DATA_W(4), .OUT_W(8))  bus4 ();

    alu_pipe #(.DATA_W(8), .OUT_W(16)) dut8 (.clk_p_i(clk), .reset_p_i(rst), .bus(bus8));
    alu_pipe #(.DATA_W(4), .OUT_W(8))  dut4 (.clk_p_i(clk), .reset_p_i(rst), .bus(bus4));

    int     checks = 0;
    int     fails = 0;
    longint acc8 = 0;
    longint acc4 = 0;
    res8_t  exp8_q[$];
    res8_t  obs8_q[$];
    res4_t  exp4_q[$];
    res4_t  obs4_q[$];
    int     hold8_err = 0;
    int     ready_low8 = 0;
    logic   hold8_pend = 1'b0;
    logic [15:0] hold8_d = '0;
    logic   hold8_s = 1'b0;
    bit     stream_done = 1'b0;

    // Passive capture of consumed results and of held-output stability.
    always @(negedge clk) begin
        if (rst) begin
            hold8_pend <= 1'b0;
        end else begin
            if (bus8.valid_o && bus8.ready_i) obs8_q.push_back({bus8.data_o, bus8.sat_o});
            if (bus4.valid_o && bus4.ready_i) obs4_q.push_back({bus4.data_o, bus4.sat_o});
            if (hold8_pend && (!bus8.valid_o || bus8.data_o !== hold8_d || bus8.sat_o !== hold8_s))
                hold8_err <= hold8_err + 1;
            if (!bus8.ready_o) ready_low8 <= ready_low8 + 1;
            hold8_pend <= bus8.valid_o && !bus8.ready_i;
            hold8_d    <= bus8.data_o;
            hold8_s    <= bus8.sat_o;
        end
    end

    function automatic longint model_op(input int ow, input int op, input longint a,
                                        input longint b, inout longint acc, output bit sat);
        longint lo = -(longint'(1) << (ow - 1));
        longint hi = (longint'(1) << (ow - 1)) - 1;
        longint r;
        sat = 1'b0;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            3: begin
                r = acc + a * b;
                if (r > hi) begin r = hi; sat = 1'b1; end
                else if (r < lo) begin r = lo; sat = 1'b1; end
                acc = r;
            end
            4: r = (a > b) ? a : b;
            5: r = (a < b) ? a : b;
            6: r = (a > b) ? a - b : b - a;
            default: begin r = acc; acc = 0; end
        endcase
        return r;
    endfunction

    task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic   rdy;
        longint r;
        bit     s;
        res8_t  e;
        int     n = 0;
        bus8.valid_i = 1'b1; bus8.inst_i = op; bus8.data_a_i = a; bus8.data_b_i = b;
        forever begin
            @(negedge clk); rdy = bus8.ready_o;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 300) begin
                checks++; fails++;
                $display("FAIL send8_timeout: ready_o stayed 0, required 1 within 300 cycles");
                break;
            end
        end
        if (rdy) begin
            r = model_op(16, int'(op), longint'($signed(a)), longint'($signed(b)), acc8, s);
            e.d = r[15:0]; e.s = s;
            exp8_q.push_back(e);
        end
        bus8.valid_i = 1'b0;
    endtask

    task automatic send4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic   rdy;
        longint r;
        bit     s;
        res4_t  e;
        int     n = 0;
        bus4.valid_i = 1'b1; bus4.inst_i = op; bus4.data_a_i = a; bus4.data_b_i = b;
        forever begin
            @(negedge clk); rdy = bus4.ready_o;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 300) begin
                checks++; fails++;
                $display("FAIL send4_timeout: ready_o stayed 0, required 1 within 300 cycles");
                break;
            end
        end
        if (rdy) begin
            r = model_op(8, int'(op), longint'($signed(a)), longint'($signed(b)), acc4, s);
            e.d = r[7:0]; e.s = s;
            exp4_q.push_back(e);
        end
        bus4.valid_i = 1'b0;
    endtask

    task automatic wait_drain8();
        int n = 0;
        while (obs8_q.size() < exp8_q.size() && n < 1000) begin @(posedge clk); #1; n++; end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain4();
        int n = 0;
        while (obs4_q.size() < exp4_q.size() && n < 1000) begin @(posedge clk); #1; n++; end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.valid_i = 0; bus8.ready_i = 1; bus8.inst_i = 0; bus8.data_a_i = 0; bus8.data_b_i = 0;
        bus4.valid_i = 0; bus4.ready_i = 1; bus4.inst_i = 0; bus4.data_a_i = 0; bus4.data_b_i = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus8.valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid8: got %b want 0", bus8.valid_o); end
        checks++; if (bus8.data_o !== 16'h0) begin fails++; $display("FAIL rst_data8: got %h want 0000", bus8.data_o); end
        checks++; if (bus8.sat_o !== 1'b0) begin fails++; $display("FAIL rst_sat8: got %b want 0", bus8.sat_o); end
        checks++; if (bus8.ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready8: got %b want 1", bus8.ready_o); end
        checks++; if (bus4.valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid4: got %b want 0", bus4.valid_o); end
        checks++; if (bus4.ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready4: got %b want 1", bus4.ready_o); end
        rst = 1'b0;
        obs8_q.delete(); exp8_q.delete(); obs4_q.delete(); exp4_q.delete();
    endtask

    task automatic test_alu_ops();
        logic [2:0] ov[6];
        logic [7:0] av[6];
        logic [7:0] bv[6];
        res8_t      want[6];
        ov = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
        av = '{8'h7F, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80};
        bv = '{8'h01, 8'h01, 8'h80, 8'h05, 8'h05, 8'h7F};
        want = '{{16'h0080, 1'b0}, {16'hFFFF, 1'b0}, {16'h4000, 1'b0},
                 {16'h0005, 1'b0}, {16'hFF80, 1'b0}, {16'h00FF, 1'b0}};
        obs8_q.delete(); exp8_q.delete();
        send8(ov[0], av[0], bv[0]);
        checks++; if (bus8.valid_o !== 1'b0) begin fails++; $display("FAIL latency_early: valid_o %b want 0", bus8.valid_o); end
        @(posedge clk); #1;
        checks++;
        if (bus8.valid_o !== 1'b1 || bus8.data_o !== 16'h0080 || bus8.sat_o !== 1'b0) begin
            fails++;
            $display("FAIL latency_2: valid %b data %h sat %b want 1 0080 0", bus8.valid_o, bus8.data_o, bus8.sat_o);
        end
        for (int i = 1; i < 6; i++) send8(ov[i], av[i], bv[i]);
        wait_drain8();
        checks++; if (obs8_q.size() != 6) begin fails++; $display("FAIL ops_count: got %0d want 6", obs8_q.size()); end
        for (int i = 0; i < 6 && i < obs8_q.size(); i++) begin
            checks++;
            if (obs8_q[i] !== want[i]) begin fails++; $display("FAIL ops[%0d]: got %h want %h", i, obs8_q[i], want[i]); end
        end
    endtask

    task automatic test_mac();
        res8_t want[6];
        want = '{{16'h0000, 1'b0}, {16'h3F01, 1'b0}, {16'h7E02, 1'b0},
                 {16'h7FFF, 1'b1}, {16'h7FFF, 1'b0}, {16'h0001, 1'b0}};
        obs8_q.delete(); exp8_q.delete();
        send8(3'd7, 8'h00, 8'h00);
        repeat (3) send8(3'd3, 8'h7F, 8'h7F);
        send8(3'd7, 8'h00, 8'h00);
        send8(3'd3, 8'h01, 8'h01);
        wait_drain8();
        checks++; if (obs8_q.size() != 6) begin fails++; $display("FAIL mac_count: got %0d want 6", obs8_q.size()); end
        for (int i = 0; i < 6 && i < obs8_q.size(); i++) begin
            checks++;
            if (obs8_q[i] !== want[i]) begin fails++; $display("FAIL mac[%0d]: got %h want %h", i, obs8_q[i], want[i]); end
        end
    endtask

    task automatic test_backpressure();
        int hold0 = hold8_err;
        int low0 = ready_low8;
        obs8_q.delete(); exp8_q.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) send8(3'd0, 8'(i * 3), 8'(i + 100));
            end
            begin
                repeat (3) begin @(posedge clk); #1; end
                bus8.ready_i = 1'b0;
                repeat (4) begin @(posedge clk); #1; end
                bus8.ready_i = 1'b1;
            end
        join
        wait_drain8();
        checks++; if (ready_low8 == low0) begin fails++; $display("FAIL bp_ready_fell: ready_o low 0 cycles, want >0"); end
        checks++; if (obs8_q.size() != 6) begin fails++; $display("FAIL bp_count: got %0d want 6", obs8_q.size()); end
        for (int i = 0; i < 6 && i < obs8_q.size(); i++) begin
            checks++;
            if (obs8_q[i] !== exp8_q[i]) begin fails++; $display("FAIL bp[%0d]: got %h want %h", i, obs8_q[i], exp8_q[i]); end
        end
        obs8_q.delete(); exp8_q.delete();
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    send8(3'($urandom_range(0, 7)), 8'($urandom()), 8'($urandom()));
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    bus8.ready_i = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                bus8.ready_i = 1'b1;
            end
        join
        wait_drain8();
        checks++;
        if (obs8_q.size() != exp8_q.size()) begin
            fails++; $display("FAIL rnd_count: got %0d want %0d", obs8_q.size(), exp8_q.size());
        end
        for (int i = 0; i < exp8_q.size() && i < obs8_q.size(); i++) begin
            checks++;
            if (obs8_q[i] !== exp8_q[i]) begin fails++; $display("FAIL rnd[%0d]: got %h want %h", i, obs8_q[i], exp8_q[i]); end
        end
        checks++; if (hold8_err != hold0) begin fails++; $display("FAIL hold_stable: %0d changes while stalled, want 0", hold8_err - hold0); end
    endtask

    task automatic test_narrow();
        res4_t want[5];
        want = '{{8'h00, 1'b0}, {8'h31, 1'b0}, {8'h62, 1'b0}, {8'h7F, 1'b1}, {8'h40, 1'b0}};
        obs4_q.delete(); exp4_q.delete();
        send4(3'd7, 4'h0, 4'h0);
        repeat (3) send4(3'd3, 4'h7, 4'h7);
        send4(3'd2, 4'h8, 4'h8);
        wait_drain4();
        checks++; if (obs4_q.size() != 5) begin fails++; $display("FAIL n_count: got %0d want 5", obs4_q.size()); end
        for (int i = 0; i < 5 && i < obs4_q.size(); i++) begin
            checks++;
            if (obs4_q[i] !== want[i]) begin fails++; $display("FAIL n[%0d]: got %h want %h", i, obs4_q[i], want[i]); end
        end
        obs4_q.delete(); exp4_q.delete();
        for (int i = 0; i < 30; i++) send4(3'($urandom_range(0, 7)), 4'($urandom()), 4'($urandom()));
        wait_drain4();
        checks++;
        if (obs4_q.size() != exp4_q.size()) begin
            fails++; $display("FAIL nrnd_count: got %0d want %0d", obs4_q.size(), exp4_q.size());
        end
        for (int i = 0; i < exp4_q.size() && i < obs4_q.size(); i++) begin
            checks++;
            if (obs4_q[i] !== exp4_q[i]) begin fails++; $display("FAIL nrnd[%0d]: got %h want %h", i, obs4_q[i], exp4_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        obs8_q.delete(); exp8_q.delete();
        bus8.ready_i = 1'b1;
        send8(3'd7, 8'h00, 8'h00);
        send8(3'd3, 8'h40, 8'h40);
        send8(3'd3, 8'h0C, 8'h2F);
        wait_drain8();
        checks++;
        if (obs8_q.size() != 3 || obs8_q[obs8_q.size() - 1] !== {16'h1234, 1'b0}) begin
            fails++; $display("FAIL rm_acc: got %0d results last %h want 3 results last 1234/0",
                              obs8_q.size(), obs8_q.size() > 0 ? obs8_q[obs8_q.size() - 1] : '0);
        end
        bus8.ready_i = 1'b0;
        send8(3'd0, 8'h01, 8'h01);
        send8(3'd0, 8'h02, 8'h02);
        checks++; if (bus8.valid_o !== 1'b1) begin fails++; $display("FAIL rm_inflight: valid_o %b want 1", bus8.valid_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus8.valid_o !== 1'b0) begin fails++; $display("FAIL rm_valid: got %b want 0", bus8.valid_o); end
        checks++; if (bus8.data_o !== 16'h0) begin fails++; $display("FAIL rm_data: got %h want 0000", bus8.data_o); end
        checks++; if (bus8.ready_o !== 1'b1) begin fails++; $display("FAIL rm_ready: got %b want 1", bus8.ready_o); end
        // An op offered while reset is held must be ignored.
        bus8.valid_i = 1'b1; bus8.inst_i = 3'd0; bus8.data_a_i = 8'h05; bus8.data_b_i = 8'h05;
        @(posedge clk); #1;
        bus8.valid_i = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        acc8 = 0; acc4 = 0;
        obs8_q.delete(); exp8_q.delete();
        bus8.ready_i = 1'b1;
        @(posedge clk); #1;
        send8(3'd3, 8'h02, 8'h03);
        wait_drain8();
        checks++; if (obs8_q.size() != 1) begin fails++; $display("FAIL rm_count: got %0d want 1", obs8_q.size()); end
        checks++;
        if (obs8_q.size() > 0 && obs8_q[0] !== {16'h0006, 1'b0}) begin
            fails++; $display("FAIL rm_mac: got %h want 0006/0", obs8_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mac();
        test_backpressure();
        test_narrow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 50000 cycles");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised successor of the 3-bit-instruction ALU. It is a two-stage pipelined signed ALU with a valid/ready handshake on both sides, a saturating multiply-accumulate register, and a status output. It sits between the operand sequencer and the result buffer, and takes in one operation per cycle when not back-pressured.

Parameters:
DATA_W, 8, operand width in bits (signed two's complement); legal range 4..32.
OUT_W, 2*DATA_W, result and accumulator width in bits (signed); must satisfy OUT_W >= 2*DATA_W.

Ports:
clk_p_i  in  1  clock; all state updates on the rising edge.
reset_p_i  in  1  reset, asynchronous, active-high.
valid_i  in  1  operand/instruction valid.
ready_o  out  1  block can accept this cycle.
data_a_i  in  DATA_W  operand A, signed.
data_b_i  in  DATA_W  operand B, signed.
inst_i  in  3  opcode.
valid_o  out  1  result valid.
ready_i  in  1  downstream accepts the result.
data_o  out  OUT_W  result, signed.
sat_o  out  1  result saturated, qualified by valid_o.

Behaviour:
- Reset (async assert): all valid bits = 0, accumulator = 0, data_o = 0, sat_o = 0, valid_o = 0. The reset value of ready_o is 1 (combinational, see below). Reset mid-operation drops all in-flight operations; no result emerges for them.
- Handshake: an input is accepted when valid_i && ready_o; a result is consumed when valid_o && ready_i.
- Pipeline stages and stall logic:
  - S1 registers {valid, inst, a, b}.
  - S2 computes the result and registers {valid, data_o, sat_o}.
  - adv2 = !s2_valid || ready_i.
  - adv1 = !s1_valid || adv2.
  - ready_o = adv1 (combinational; no dependence on valid_i).
- Latency is exactly 2 cycles from acceptance to valid_o when ready_i is held at 1. Throughput is 1 per cycle.
- While valid_o && !ready_i, data_o and sat_o hold stable. No operation is lost or duplicated.
- Opcodes. All arithmetic sign-extends operands to OUT_W first.
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 MUL: a*b (full product).
  - 011 MAC: acc <= sat(acc + a*b); data_o = new acc.
  - 100 MAX: signed max(a,b).
  - 101 MIN: signed min(a,b).
  - 110 ABSDIFF: |a-b|.
  - 111 CLR: acc <= 0; data_o = old acc value (read-and-clear).
- Overflow and saturation:
  - ADD, SUB, MUL, ABSDIFF cannot overflow OUT_W; sat_o = 0 for them.
  - MAC saturates to +(2^(OUT_W-1)-1) or -2^(OUT_W-1) and sets sat_o = 1 for that result only.
- Accumulator commits only when the MAC/CLR operation moves S1 -> S2 (s1_valid && adv2). A stalled MAC does not update acc twice.
- Back-to-back MACs use the accumulator value from the previous cycle's commit. No hazard bubble.
- Simultaneous reset and valid_i: reset wins; the input is not accepted.

Decomposition:
- Package alu_pipe_pkg holds:
  - opcode enum (OP_ADD..OP_CLR, 3 bits);
  - a function sat_add(acc, prod) returning {sat, value}.
- One sub-module is natural: alu_pipe_mac, which holds the accumulator register, the saturating adder and the commit enable. The ALU ops stay in the top level.

Test Plan:
1. Default params, ready_i=1, ADD 0x7F,0x01 -> after 2 cycles valid_o=1, data_o=0x0080, sat_o=0. Then SUB 0x00,0x01 -> 0xFFFF.
2. MUL 0x80,0x80 -> 0x4000. MAX 0x80,0x05 -> 0x0005. MIN 0x80,0x05 -> 0xFF80. ABSDIFF 0x80,0x7F -> 0x00FF.
3. CLR, then MAC 0x7F,0x7F three times back-to-back -> outputs 0x3F01, 0x7E02, 0x7FFF with sat_o=0,0,1. Then CLR -> data_o=0x7FFF and acc=0, so the next MAC 0x01,0x01 -> 0x0001.
4. Backpressure: stream 6 ADDs with ready_i low for cycles 3-6 -> ready_o falls once both stages are full; data_o is held stable; all 6 results emerge in order with no loss or duplicate. MACs under stall accumulate exactly once each.
5. Reset mid-stream: assert reset_p_i asynchronously (off-edge) with 2 ops in flight and acc=0x1234 -> valid_o=0 immediately, acc=0. After release, MAC 0x02,0x03 -> 0x0006.
6. DATA_W=4, OUT_W=8: MAC 0x7,0x7 repeated 3 times -> 0x31, 0x62, 0x7F with sat_o=1 on the third. MUL 0x8,0x8 -> 0x40.
